// File: rtl/sci_sync_link.sv
// Clocked-synchronous partner for the SH7604 SCI: TXD bytes into an RX FIFO, TX FIFO bytes onto RXD.
// Latency: RX_VALID one CLK after the 8th SCK rise, RXD one CLK after a fall; RX overflow drops the byte, TX empty sends IDLE_BYTE.
module sci_sync_link #(
    parameter int         FIFO_DEPTH   = 4,
    parameter int         IDLE_TIMEOUT = 1023,
    parameter logic [7:0] IDLE_BYTE    = 8'hFF
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       CE,
    input  logic       SCK,
    input  logic       TXD,
    output logic       RXD,
    output logic [7:0] RX_DATA,
    output logic       RX_VALID,
    input  logic       RX_READY,
    input  logic [7:0] TX_DATA,
    input  logic       TX_VALID,
    output logic       TX_READY,
    output logic       RX_OVF,
    input  logic       OVF_CLR,
    output logic       TX_UNDERRUN,
    output logic       FRAME_ERR
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int IW = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [CW-1:0] DEPTH   = CW'(FIFO_DEPTH);
    localparam logic [IW-1:0] TIMEOUT = IW'(IDLE_TIMEOUT);

    logic          sck_q, sck_d;
    logic [6:0]    rsr_q, rsr_d;
    logic [2:0]    rbit_q, rbit_d;
    logic [6:0]    tsr_q, tsr_d;
    logic [2:0]    tbit_q, tbit_d;
    logic          rxd_q, rxd_d;
    logic [IW-1:0] idle_q, idle_d;
    logic          ovf_q, ovf_d;
    logic          und_q, und_d;
    logic          ferr_q, ferr_d;

    logic [7:0]    rx_mem_q [FIFO_DEPTH];
    logic [7:0]    rx_mem_d [FIFO_DEPTH];
    logic [AW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [7:0]    tx_mem_q [FIFO_DEPTH];
    logic [7:0]    tx_mem_d [FIFO_DEPTH];
    logic [AW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;

    logic       rise, fall, abort;
    logic       rx_pop, rx_push_req, rx_push;
    logic       tx_push, tx_pop, frame_start;
    logic [7:0] rx_byte, tx_byte;

    always_comb begin
        rise  = CE & SCK & ~sck_q;
        fall  = CE & ~SCK & sck_q;
        sck_d = CE ? SCK : sck_q;

        // An edge restarts the idle window, so it always wins over the timeout.
        abort  = (idle_q == TIMEOUT) && ((rbit_q != 3'd0) || (tbit_q != 3'd0)) && !(rise || fall);
        idle_d = idle_q;
        if (rise || fall) begin
            idle_d = '0;
        end else if (CE && (idle_q != TIMEOUT)) begin
            idle_d = idle_q + IW'(1);
        end

        // rsr holds the upper 7 bits of the shifter; bit 0 would be shifted out before use.
        rx_byte     = {TXD, rsr_q};
        rx_pop      = RX_READY && (rx_cnt_q != '0);
        rx_push_req = rise && (rbit_q == 3'd7);
        rx_push     = rx_push_req && ((rx_cnt_q != DEPTH) || rx_pop);
        rsr_d       = rsr_q;
        rbit_d      = rbit_q;
        if (abort) begin
            rbit_d = 3'd0;
        end else if (rise) begin
            rsr_d  = rx_byte[7:1];
            rbit_d = rbit_q + 3'd1;
        end

        ovf_d = ovf_q;
        if (rx_push_req && !rx_push) begin
            ovf_d = 1'b1;
        end else if (OVF_CLR) begin
            ovf_d = 1'b0;
        end

        rx_mem_d = rx_mem_q;
        rx_wr_d  = rx_wr_q;
        rx_rd_d  = rx_rd_q;
        if (rx_push) begin
            rx_mem_d[rx_wr_q] = rx_byte;
            rx_wr_d           = rx_wr_q + AW'(1);
        end
        if (rx_pop) begin
            rx_rd_d = rx_rd_q + AW'(1);
        end
        case ({rx_push, rx_pop})
            2'b10:   rx_cnt_d = rx_cnt_q + CW'(1);
            2'b01:   rx_cnt_d = rx_cnt_q - CW'(1);
            default: rx_cnt_d = rx_cnt_q;
        endcase

        // A host push into an empty FIFO lands after the frame-start pop decision.
        tx_push     = TX_VALID && (tx_cnt_q != DEPTH);
        frame_start = fall && (tbit_q == 3'd0);
        tx_pop      = frame_start && (tx_cnt_q != '0);
        tx_byte     = tx_pop ? tx_mem_q[tx_rd_q] : IDLE_BYTE;
        und_d       = frame_start && !tx_pop;
        ferr_d      = abort;

        tsr_d  = tsr_q;
        tbit_d = tbit_q;
        rxd_d  = rxd_q;
        if (abort) begin
            tbit_d = 3'd0;
            rxd_d  = 1'b1;
        end else if (frame_start) begin
            rxd_d  = tx_byte[0];
            tsr_d  = tx_byte[7:1];
            tbit_d = 3'd1;
        end else if (fall) begin
            rxd_d  = tsr_q[0];
            tsr_d  = {1'b0, tsr_q[6:1]};
            tbit_d = tbit_q + 3'd1;
        end

        tx_mem_d = tx_mem_q;
        tx_wr_d  = tx_wr_q;
        tx_rd_d  = tx_rd_q;
        if (tx_push) begin
            tx_mem_d[tx_wr_q] = TX_DATA;
            tx_wr_d           = tx_wr_q + AW'(1);
        end
        if (tx_pop) begin
            tx_rd_d = tx_rd_q + AW'(1);
        end
        case ({tx_push, tx_pop})
            2'b10:   tx_cnt_d = tx_cnt_q + CW'(1);
            2'b01:   tx_cnt_d = tx_cnt_q - CW'(1);
            default: tx_cnt_d = tx_cnt_q;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sck_q    <= 1'b1;
            rsr_q    <= '0;
            rbit_q   <= '0;
            tsr_q    <= '0;
            tbit_q   <= '0;
            rxd_q    <= 1'b1;
            idle_q   <= '0;
            ovf_q    <= 1'b0;
            und_q    <= 1'b0;
            ferr_q   <= 1'b0;
            rx_wr_q  <= '0;
            rx_rd_q  <= '0;
            rx_cnt_q <= '0;
            tx_wr_q  <= '0;
            tx_rd_q  <= '0;
            tx_cnt_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                rx_mem_q[i] <= '0;
                tx_mem_q[i] <= '0;
            end
        end else begin
            sck_q    <= sck_d;
            rsr_q    <= rsr_d;
            rbit_q   <= rbit_d;
            tsr_q    <= tsr_d;
            tbit_q   <= tbit_d;
            rxd_q    <= rxd_d;
            idle_q   <= idle_d;
            ovf_q    <= ovf_d;
            und_q    <= und_d;
            ferr_q   <= ferr_d;
            rx_wr_q  <= rx_wr_d;
            rx_rd_q  <= rx_rd_d;
            rx_cnt_q <= rx_cnt_d;
            tx_wr_q  <= tx_wr_d;
            tx_rd_q  <= tx_rd_d;
            tx_cnt_q <= tx_cnt_d;
            rx_mem_q <= rx_mem_d;
            tx_mem_q <= tx_mem_d;
        end
    end

    assign RXD         = rxd_q;
    assign RX_DATA     = rx_mem_q[rx_rd_q];
    assign RX_VALID    = (rx_cnt_q != '0);
    assign TX_READY    = (tx_cnt_q != DEPTH);
    assign RX_OVF      = ovf_q;
    assign TX_UNDERRUN = und_q;
    assign FRAME_ERR   = ferr_q;

endmodule

// File: tb/tb_sci_sync_link.sv
// Directed bench for sci_sync_link: a queue-based model of the serial link is checked every cycle,
// plus literal expectations for the byte-level scenarios.
module tb_sci_sync_link;
    localparam int         DEPTH = 4;
    localparam int         TO    = 64;
    localparam logic [7:0] IDLE  = 8'hFF;
    localparam int PUSH_AT_FALL    = 1;
    localparam int PUSH_AFTER_FALL = 2;
    localparam int POP_LAST        = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ce = 1'b0;
    logic       sck = 1'b1;
    logic       txd = 1'b1;
    logic       rx_ready = 1'b0;
    logic       tx_valid = 1'b0;
    logic       ovf_clr = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       rxd, rx_valid, tx_ready, rx_ovf, tx_underrun, frame_err;
    logic [7:0] rx_data;

    int   compared = 0;
    int   mismatched = 0;
    bit   check_en = 1'b0;
    int   und_cnt = 0;
    int   fe_cnt = 0;
    logic [7:0] samp_byte;
    logic [7:0] push_byte = 8'h00;
    logic       und0;

    // Model state
    logic [7:0] m_rxq[$];
    logic [7:0] m_txq[$];
    logic m_sck, m_rxd, m_ovf, m_und, m_ferr;
    int   m_idle, m_rbit, m_racc, m_tbit, m_tcur;

    sci_sync_link #(.FIFO_DEPTH(DEPTH), .IDLE_TIMEOUT(TO), .IDLE_BYTE(IDLE)) dut (
        .CLK(clk), .RST_N(rst_n), .CE(ce), .SCK(sck), .TXD(txd), .RXD(rxd),
        .RX_DATA(rx_data), .RX_VALID(rx_valid), .RX_READY(rx_ready),
        .TX_DATA(tx_data), .TX_VALID(tx_valid), .TX_READY(tx_ready),
        .RX_OVF(rx_ovf), .OVF_CLR(ovf_clr), .TX_UNDERRUN(tx_underrun), .FRAME_ERR(frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_rxq.delete();
        m_txq.delete();
        m_sck = 1'b1; m_rxd = 1'b1; m_ovf = 1'b0; m_und = 1'b0; m_ferr = 1'b0;
        m_idle = 0; m_rbit = 0; m_racc = 0; m_tbit = 0; m_tcur = 0;
    endtask

    task automatic model_step();
        bit rise, fall, rpop, tpush, ovf_set;
        rise    = ce && sck && !m_sck;
        fall    = ce && !sck && m_sck;
        rpop    = rx_ready && (m_rxq.size() != 0);
        tpush   = tx_valid && (m_txq.size() < DEPTH);
        ovf_set = 1'b0;
        m_und   = 1'b0;
        m_ferr  = 1'b0;
        if (rpop) void'(m_rxq.pop_front());
        if (!rise && !fall && m_idle == TO && (m_rbit != 0 || m_tbit != 0)) begin
            m_rbit = 0; m_racc = 0; m_tbit = 0; m_rxd = 1'b1; m_ferr = 1'b1;
        end else begin
            if (rise) begin
                m_racc = m_racc | (int'(txd) << m_rbit);
                m_rbit++;
                if (m_rbit == 8) begin
                    if (m_rxq.size() < DEPTH) m_rxq.push_back(8'(m_racc));
                    else ovf_set = 1'b1;
                    m_rbit = 0;
                    m_racc = 0;
                end
            end
            if (fall) begin
                if (m_tbit == 0) begin
                    if (m_txq.size() != 0) m_tcur = int'(m_txq.pop_front());
                    else begin
                        m_tcur = int'(IDLE);
                        m_und  = 1'b1;
                    end
                end
                m_rxd  = 1'((m_tcur >> m_tbit) & 1);
                m_tbit = (m_tbit + 1) % 8;
            end
        end
        if (ovf_set) m_ovf = 1'b1;
        else if (ovf_clr) m_ovf = 1'b0;
        if (tpush) m_txq.push_back(tx_data);
        if (rise || fall) m_idle = 0;
        else if (ce && m_idle < TO) m_idle++;
        if (ce) m_sck = sck;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    initial forever begin
        @(negedge clk);
        if (check_en && rst_n) begin
            chk("rxd", int'(rxd), int'(m_rxd));
            chk("rx_valid", int'(rx_valid), int'(m_rxq.size() != 0));
            if (m_rxq.size() != 0) chk("rx_data", int'(rx_data), int'(m_rxq[0]));
            chk("tx_ready", int'(tx_ready), int'(m_txq.size() < DEPTH));
            chk("rx_ovf", int'(rx_ovf), int'(m_ovf));
            chk("tx_underrun", int'(tx_underrun), int'(m_und));
            chk("frame_err", int'(frame_err), int'(m_ferr));
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rst_n) begin
            if (tx_underrun) und_cnt++;
            if (frame_err) fe_cnt++;
        end
    end

    task automatic cyc(input logic c, input logic s);
        ce  = c;
        sck = s;
        @(negedge clk);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n, input int gap, input int mode);
        for (int i = 0; i < n; i++) begin
            txd = b[i];
            if (i == 0 && (mode & PUSH_AT_FALL) != 0) begin
                tx_valid = 1'b1;
                tx_data  = push_byte;
            end
            cyc(1'b1, 1'b0);
            tx_valid = 1'b0;
            if (i == 0 && (mode & PUSH_AFTER_FALL) != 0) begin
                tx_valid = 1'b1;
                tx_data  = push_byte;
                cyc(1'b0, 1'b0);
                tx_valid = 1'b0;
            end
            repeat (gap) cyc(1'b0, 1'b0);
            samp_byte[i] = rxd;
            if (i == 0) und0 = tx_underrun;
            if (i == n - 1 && (mode & POP_LAST) != 0) rx_ready = 1'b1;
            cyc(1'b1, 1'b1);
            rx_ready = 1'b0;
            repeat (gap) cyc(1'b0, 1'b1);
        end
    endtask

    task automatic host_push(input logic [7:0] d);
        tx_valid = 1'b1;
        tx_data  = d;
        cyc(1'b0, sck);
        tx_valid = 1'b0;
    endtask

    task automatic pop_expect(input string nm, input int e);
        chk({nm, "_vld"}, int'(rx_valid), 1);
        chk(nm, int'(rx_data), e);
        rx_ready = 1'b1;
        cyc(1'b0, sck);
        rx_ready = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i <= DEPTH; i++) begin
            if (rx_valid) begin
                rx_ready = 1'b1;
                cyc(1'b0, sck);
                rx_ready = 1'b0;
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_rxd", int'(rxd), 1);
        chk("rst_rx_valid", int'(rx_valid), 0);
        chk("rst_rx_data", int'(rx_data), 0);
        chk("rst_tx_ready", int'(tx_ready), 1);
        chk("rst_rx_ovf", int'(rx_ovf), 0);
        chk("rst_tx_underrun", int'(tx_underrun), 0);
        chk("rst_frame_err", int'(frame_err), 0);
        rst_n    = 1'b1;
        check_en = 1'b1;
        cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b1);

        // Receive 0xA5 LSB first
        send_bits(8'hA5, 8, 0, 0);
        chk("rx_a5_vld", int'(rx_valid), 1);
        chk("rx_a5", int'(rx_data), 'hA5);
        rx_ready = 1'b1;
        cyc(1'b0, 1'b1);
        rx_ready = 1'b0;
        chk("rx_popped_vld", int'(rx_valid), 0);

        // Transmit 0x3C with CE gaps between SCK edges
        host_push(8'h3C);
        send_bits(8'h00, 8, 1, 0);
        chk("tx_3c", int'(samp_byte), 'h3C);
        chk("tx_3c_ready", int'(tx_ready), 1);
        drain();

        // Underrun, with a host push landing on the frame-start cycle
        und_cnt   = 0;
        push_byte = 8'h5A;
        send_bits(8'h00, 8, 0, PUSH_AT_FALL);
        cyc(1'b0, 1'b1);
        chk("und_rxd", int'(samp_byte), 'hFF);
        chk("und_first_fall", int'(und0), 1);
        chk("und_count", und_cnt, 1);
        und_cnt = 0;
        send_bits(8'h00, 8, 0, 0);
        cyc(1'b0, 1'b1);
        chk("queued_5a", int'(samp_byte), 'h5A);
        chk("no_underrun", und_cnt, 0);
        drain();

        // Overflow: five bytes into a four-deep FIFO; clear held during the set stays set
        for (int k = 1; k <= 5; k++) begin
            if (k == 5) ovf_clr = 1'b1;
            send_bits(8'(k), 8, 0, 0);
        end
        ovf_clr = 1'b0;
        chk("ovf_set", int'(rx_ovf), 1);
        for (int k = 1; k <= 4; k++) pop_expect("ovf_pop", k);
        chk("ovf_empty", int'(rx_valid), 0);
        chk("ovf_sticky", int'(rx_ovf), 1);
        ovf_clr = 1'b1;
        cyc(1'b0, 1'b1);
        ovf_clr = 1'b0;
        chk("ovf_clr", int'(rx_ovf), 0);

        // Idle timeout mid-frame
        host_push(8'h00);
        fe_cnt = 0;
        send_bits(8'h07, 3, 0, 0);
        chk("to_mid_rxd", int'(rxd), 0);
        repeat (TO + 3) cyc(1'b1, 1'b1);
        chk("to_fe_count", fe_cnt, 1);
        chk("to_rxd_idle", int'(rxd), 1);
        chk("to_no_rx", int'(rx_valid), 0);
        send_bits(8'h81, 8, 0, 0);
        chk("to_rx81_vld", int'(rx_valid), 1);
        chk("to_rx81", int'(rx_data), 'h81);
        chk("to_fe_once", fe_cnt, 1);
        drain();

        // Full-duplex stress: both FIFOs full, pointers wrap
        for (int k = 0; k < 4; k++) send_bits(8'('h10 + k), 8, 0, 0);
        for (int k = 0; k < 4; k++) host_push(8'('h40 + k));
        chk("tx_full", int'(tx_ready), 0);
        host_push(8'hEE);
        for (int k = 0; k < 6; k++) begin
            push_byte = 8'('h44 + k);
            send_bits(8'('h20 + k), 8, k % 2, PUSH_AFTER_FALL | POP_LAST);
            chk("stress_tx", int'(samp_byte), 'h40 + k);
        end
        chk("stress_ovf", int'(rx_ovf), 0);
        for (int k = 0; k < 4; k++) pop_expect("stress_pop", 'h22 + k);

        // Reset in the middle of a frame
        send_bits(8'hFF, 3, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("mrst_rxd", int'(rxd), 1);
        chk("mrst_rx_valid", int'(rx_valid), 0);
        chk("mrst_rx_data", int'(rx_data), 0);
        chk("mrst_tx_ready", int'(tx_ready), 1);
        chk("mrst_rx_ovf", int'(rx_ovf), 0);
        @(negedge clk);
        cyc(1'b0, 1'b1);
        rst_n = 1'b1;
        cyc(1'b0, 1'b1);
        send_bits(8'h3E, 8, 0, 0);
        chk("post_rst_rx", int'(rx_data), 'h3E);
        cyc(1'b0, 1'b1);

        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
